// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the serial nibble adder.
// Holds the FSM state encoding and the slice width.
package nibble_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add_seq_if.sv
// Operand/result handshake bundle for nibble_add_seq.
// master drives operands and out_ready; slave is the adder.
// Optional sub input exists only with NIBBLE_ADD_SEQ_SUB_EN.
import nibble_add_pkg::*;

interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = SLICE_W * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         busy;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, busy
    );
    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, carry_out, busy
    );
`else
    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, carry_out, busy
    );
    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result, carry_out, busy
    );
`endif

endinterface

// File: rtl/nibble_add.sv
// Combinational 4-bit slice adder with carry in/out.
// Ports: a_i, b_i, cin_i -> sum_o, cout_o.
import nibble_add_pkg::*;

module nibble_add (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i}
                           + {1'b0, b_i}
                           + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/nibble_add_seq.sv
// Serial adder: one 4-bit slice per cycle, LSB first.
// Ports: clk, rst_n (async, active low), bus (slave).
// Define NIBBLE_ADD_SEQ_SUB_EN to add a subtract mode.
import nibble_add_pkg::*;

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    nibble_add_seq_if.slave bus
);

    localparam int W  = SLICE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES + 1);
    localparam logic [IW-1:0] FIN = IW'(NIBBLES);

    state_e         state_q;
    logic [IW-1:0]  idx_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry_q;
    logic [W-1:0]   result_q;
    logic           carry_out_q;
    logic           out_valid_q;
    logic           in_ready_q;
    logic           busy_q;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic           sub_q;
`endif

    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] sum_s;
    logic               cout_s;
    logic [W-1:0]       result_d;

    // Select the operand slices addressed by idx_q.
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_s = a_q[i*SLICE_W +: SLICE_W];
                b_s = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    // a - b = a + ~b + 1; the +1 comes from the preset carry.
    assign b_eff = sub_q ? ~b_s : b_s;
`else
    assign b_eff = b_s;
`endif

    nibble_add u_add (
        .a_i    (a_s),
        .b_i    (b_eff),
        .cin_i  (carry_q),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    // Only the current slice field changes; others hold.
    always_comb begin
        result_d = result_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                result_d[i*SLICE_W +: SLICE_W] = sum_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_b;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                        sub_q      <= bus.sub;
                        carry_q    <= bus.sub;
`else
                        carry_q    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // idx_q == FIN is a closing cycle after the
                    // last slice, so out_valid rises NIBBLES+1
                    // edges after the accept edge.
                    if (idx_q == FIN) begin
                        carry_out_q <= carry_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        result_q <= result_d;
                        carry_q  <= cout_s;
                        idx_q    <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (NIBBLES=4).
// Vector table plus handshake, backpressure and reset sequences.
module tb_nibble_add_seq;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    nibble_add_seq_if #(.NIBBLES(N)) bus ();

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        co;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_ops(input logic [15:0] a,
                             input logic [15:0] b,
                             input logic s);
        bus.op_a = a;
        bus.op_b = b;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub ignored in add-only build");
`endif
    endtask

    // Full transaction with out_ready high; checks latency too.
    task automatic run_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic s,
                          input logic [15:0] er,
                          input logic eco,
                          input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        drive_ops(a, b, s);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd5);
        check({tag, " result"}, 32'(bus.result), 32'(er));
        check({tag, " carry"}, 32'(bus.carry_out), 32'(eco));
        @(negedge clk);
        check({tag, " ov_pulse"}, 32'(bus.out_valid), 32'd0);
        check({tag, " ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops(16'h0, 16'h0, 1'b0);

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst result", 32'(bus.result), 32'd0);
        check("rst carry", 32'(bus.carry_out), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);

        // Table vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].res, vecs[i].co, $sformatf("vec%0d", i));
        end

        // Backpressure: 0x0F0F + 0x0101 held for 10 cycles.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_ops(16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp latency", 32'(n), 32'd5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp result", 32'(bus.result), 32'h1010);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            check("bp busy", 32'(bus.busy), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp release ov", 32'(bus.out_valid), 32'd0);
        check("bp release rdy", 32'(bus.in_ready), 32'd1);

        // Ignored input during RUN.
        bus.in_valid = 1'b1;
        drive_ops(16'h0001, 16'h0002, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_ops(16'hAAAA, 16'h5555, 1'b0);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ign result", 32'(bus.result), 32'h0003);
        check("ign carry", 32'(bus.carry_out), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("ign no_extra", 32'(seen), 32'd0);
        check("ign busy", 32'(bus.busy), 32'd0);

        // Reset during slice 2.
        bus.in_valid = 1'b1;
        drive_ops(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid result", 32'(bus.result), 32'd0);
        check("mid carry", 32'(bus.carry_out), 32'd0);
        check("mid out_valid", 32'(bus.out_valid), 32'd0);
        check("mid busy0", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid no_ov", 32'(seen), 32'd0);
        check("mid in_ready", 32'(bus.in_ready), 32'd1);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES, NIBBLES >= 1).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: op_a  input  W  first operand, unsigned.
REQ-007 SHALL have port: op_b  input  W  second operand, unsigned.
REQ-008 SHALL have port: out_valid  output  1  result held and valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: result  output  W  sum (or difference with the subtract feature).
REQ-011 SHALL have port: carry_out  output  1  carry from the final slice.
REQ-012 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready, capturing op_a/op_b into internal registers and clearing the carry register, then moving to RUN.
REQ-015 SHALL in RUN process one 4-bit slice per cycle, LSB slice first, index 0..NIBBLES-1, feeding the registered carry into the slice adder and storing the slice carry-out for the next slice.
REQ-016 SHALL write each slice sum into the matching 4-bit field of result; unprocessed fields keep their previous value.
REQ-017 SHALL move from RUN to DONE after slice NIBBLES-1; out_valid rises exactly NIBBLES+1 cycles after the accept edge.
REQ-018 SHALL hold result, carry_out and out_valid stable in DONE until out_valid && out_ready, then return to IDLE (in_ready high next cycle).
REQ-019 SHALL ignore in_valid and operand changes while in RUN or DONE.
REQ-020 SHALL wrap arithmetic modulo 2^W, with the discarded bit reported on carry_out.
REQ-021 SHALL, when out_ready is already high on DONE entry, complete the output handshake in that first DONE cycle.

Reset
REQ-022 SHALL on rst_n low, at any time including mid-RUN, immediately force state IDLE, slice index 0, carry register 0, result 0, carry_out 0, out_valid 0, busy 0; in_ready goes high once reset is released.
REQ-023 SHALL discard any partially computed result on reset; no output handshake occurs for it.

Configuration
REQ-024 SHALL, with macro NIBBLE_ADD_SEQ_SUB_EN defined, add input port sub (1 bit, captured at accept) selecting op_a - op_b: the slice adder sees inverted op_b and the carry register is initialised to 1; carry_out = 1 means no borrow.
REQ-025 SHALL, without NIBBLE_ADD_SEQ_SUB_EN, omit the sub port and perform addition only, with the carry register initialised to 0.

Structure
REQ-026 SHALL take the FSM state enum (IDLE/RUN/DONE) and the slice width constant (4) from shared package nibble_add_pkg.
REQ-027 SHALL instantiate exactly one sub-module nibble_add (4-bit a, b, cin -> 4-bit sum, cout, purely combinational), reused for every slice.

Verification (NIBBLES=4)
REQ-028 SHALL check that accepting 0x1234 + 0x4321 with out_ready=1 gives result 0x5555, carry_out 0, out_valid high for one cycle exactly 5 cycles after the accept edge.
REQ-029 SHALL check the carry chain: 0xFFFF + 0x0001 -> result 0x0000, carry_out 1; 0x0FFF + 0x0001 -> 0x1000, carry_out 0.
REQ-030 SHALL check backpressure: with out_ready=0 for 10 cycles, result and out_valid stay stable and in_ready stays 0; on out_ready=1 the handshake completes and in_ready returns the following cycle.
REQ-031 SHALL check ignored input: in_valid pulsed with 0xAAAA/0x5555 during RUN does not alter the in-flight 0x0001 + 0x0002 result 0x0003.
REQ-032 SHALL check reset mid-operation: rst_n low during slice 2 clears all outputs to 0 with no out_valid; a new operation after release (0x00FF + 0x0001 -> 0x0100) is correct.
REQ-033 SHALL check with NIBBLE_ADD_SEQ_SUB_EN: sub=1, 0x0005 - 0x0007 -> result 0xFFFE, carry_out 0; 0x0007 - 0x0005 -> 0x0002, carry_out 1.
